// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - anode codes, display word type and refresh helpers for display_scan_driver
package display_pkg;

  localparam logic [3:0] DIG0_SEL = 4'b1110;
  localparam logic [3:0] DIG1_SEL = 4'b1101;
  localparam logic [3:0] DIG2_SEL = 4'b1011;
  localparam logic [3:0] DIG3_SEL = 4'b0111;
  localparam logic [3:0] DIG_OFF  = 4'b1111;

  typedef struct packed {
    logic [5:0] value;
    logic       negative;
    logic       is_dec;
  } disp_word_t;

  localparam disp_word_t DISP_RESET = '{value: 6'd0, negative: 1'b0, is_dec: 1'b1};

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  function automatic int tick_div(input int clk_hz, input int refresh_hz);
    return clk_hz / refresh_hz;
  endfunction

  function automatic logic [3:0] slot_sel(input slot_t s);
    case (s)
      SLOT0:   return DIG0_SEL;
      SLOT1:   return DIG1_SEL;
      SLOT2:   return DIG2_SEL;
      default: return DIG3_SEL;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_driver_prescaler.sv
// rtl/display_scan_driver_prescaler.sv - modulo-DIV refresh counter with terminal-count tick
module refresh_prescaler #(
  parameter int DIV = 10,
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] count,
  output logic         tick
);

  assign tick = (count == W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - 4-digit anode scan with frame-aligned value/sign/radix update
// Optional anode dead-time at the start of each slot: define DIGIT_BLANK_EN.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic [5:0] value_in,
  input  logic       negative_in,
  input  logic       is_dec_in,
  output logic [3:0] digit,
  output logic [5:0] display_value,
  output logic       show_negative,
  output logic       is_dec,
  output logic       frame_tick
);

  localparam int TICK_DIV = tick_div(CLK_HZ, REFRESH_HZ);
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 2) begin : g_div_chk
    $error("display_scan_driver: TICK_DIV must be at least 2");
  end
  if (BLANK_CYCLES < 0) begin : g_blank_sign_chk
    $error("display_scan_driver: BLANK_CYCLES must be non-negative");
  end
`ifdef DIGIT_BLANK_EN
  if (BLANK_CYCLES >= TICK_DIV) begin : g_blank_chk
    $error("display_scan_driver: BLANK_CYCLES must be less than TICK_DIV");
  end
`endif

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             tick;
  slot_t            slot;
  slot_t            slot_next;
  logic             wrap;
  logic [3:0]       digit_next;
  disp_word_t       in_word;
  disp_word_t       shadow;
  disp_word_t       live;
  logic             pending;

  refresh_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .tick  (tick)
  );

  // digit is registered from the next-state index so it flips on the same edge as the slot
  assign count_next = tick ? '0 : count + 1'b1;
  assign slot_next  = tick ? slot_t'(slot + 2'd1) : slot;
  assign wrap       = tick && (slot == SLOT3);
  assign in_word    = '{value: value_in, negative: negative_in, is_dec: is_dec_in};

`ifdef DIGIT_BLANK_EN
  assign digit_next = (count_next < CNT_W'(BLANK_CYCLES)) ? DIG_OFF : slot_sel(slot_next);
`else
  assign digit_next = slot_sel(slot_next);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot       <= SLOT0;
      digit      <= DIG_OFF;
      frame_tick <= 1'b0;
      shadow     <= DISP_RESET;
      live       <= DISP_RESET;
      pending    <= 1'b0;
    end else begin
      slot       <= slot_next;
      digit      <= digit_next;
      frame_tick <= wrap;
      if (update) begin
        shadow <= in_word;
      end
      // an update landing on the wrap edge bypasses the shadow so it is not delayed a frame
      if (wrap) begin
        if (update) begin
          live <= in_word;
        end else if (pending) begin
          live <= shadow;
        end
        pending <= 1'b0;
      end else if (update) begin
        pending <= 1'b1;
      end
    end
  end

  assign display_value = live.value;
  assign show_negative = live.negative;
  assign is_dec        = live.is_dec;

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - directed self-checking bench for display_scan_driver
module tb_display_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       update = 1'b0;
  logic [5:0] value_in = 6'd0;
  logic       negative_in = 1'b0;
  logic       is_dec_in = 1'b1;
  logic [3:0] digit;
  logic [5:0] display_value;
  logic       show_negative;
  logic       is_dec;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  int c = 0;

  display_scan_driver #(
    .CLK_HZ       (1000),
    .REFRESH_HZ   (100),
    .BLANK_CYCLES (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .update        (update),
    .value_in      (value_in),
    .negative_in   (negative_in),
    .is_dec_in     (is_dec_in),
    .digit         (digit),
    .display_value (display_value),
    .show_negative (show_negative),
    .is_dec        (is_dec),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  // c counts clock edges since reset release; slots change on multiples of 10
  function automatic logic [3:0] exp_digit(input int cyc);
    int idx;
    int cnt;
    if (cyc == 0) return 4'b1111;
    idx = (cyc / 10) % 4;
    cnt = cyc % 10;
`ifdef DIGIT_BLANK_EN
    if (cnt < 3) return 4'b1111;
`endif
    case (idx)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic tick1();
    @(posedge clk);
    #1;
    c++;
    check("digit", 32'(digit), 32'(exp_digit(c)));
    check("frame_tick", 32'(frame_tick), 32'((c > 0) && (c % 40 == 0)));
  endtask

  task automatic run_to(input int target);
    while (c < target) tick1();
  endtask

  task automatic check_live(input string tag, input logic [5:0] v, input logic n, input logic d);
    check({tag, ".value"}, 32'(display_value), 32'(v));
    check({tag, ".neg"}, 32'(show_negative), 32'(n));
    check({tag, ".dec"}, 32'(is_dec), 32'(d));
  endtask

  task automatic pulse_update(input logic [5:0] v, input logic n, input logic d);
    value_in    = v;
    negative_in = n;
    is_dec_in   = d;
    update      = 1'b1;
    tick1();
    update      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset held
    repeat (3) @(posedge clk);
    #1;
    check("rst.digit", 32'(digit), 32'h0000_000f);
    check("rst.frame_tick", 32'(frame_tick), 32'd0);
    check_live("rst", 6'd0, 1'b0, 1'b1);
    rst = 1'b0;
    c = 0;

    // scan sequence across one full frame plus a bit
    run_to(45);

    // update at slot 1 is held until the wrap
    run_to(52);
    pulse_update(6'd42, 1'b1, 1'b1);
    run_to(60);
    check_live("t2.mid", 6'd0, 1'b0, 1'b1);
    run_to(79);
    check_live("t2.prewrap", 6'd0, 1'b0, 1'b1);
    run_to(80);
    check_live("t2.wrap", 6'd42, 1'b1, 1'b1);

    // last of several updates within a frame wins
    run_to(85);
    pulse_update(6'd5, 1'b0, 1'b0);
    run_to(90);
    pulse_update(6'd9, 1'b0, 1'b1);
    run_to(119);
    check_live("t3.prewrap", 6'd42, 1'b1, 1'b1);
    run_to(120);
    check_live("t3.wrap", 6'd9, 1'b0, 1'b1);

    // update coinciding with the wrap edge is applied on that edge
    run_to(159);
    pulse_update(6'd17, 1'b0, 1'b0);
    check_live("t4.wrap", 6'd17, 1'b0, 1'b0);
    check("t4.pending", 32'(dut.pending), 32'd0);
    run_to(200);
    check_live("t4.next", 6'd17, 1'b0, 1'b0);

    // async reset mid-slot 2 discards a pending update
    run_to(205);
    pulse_update(6'd33, 1'b1, 1'b1);
    run_to(225);
    #2;
    rst = 1'b1;
    #1;
    check("t5.digit", 32'(digit), 32'h0000_000f);
    check("t5.frame_tick", 32'(frame_tick), 32'd0);
    check_live("t5.async", 6'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    c = 0;
    run_to(40);
    check_live("t5.after", 6'd0, 1'b0, 1'b1);
    run_to(81);
    check_live("t5.later", 6'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
